// File: rtl/iter_multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// The ITER_MUL_EARLY_TERM_EN option is handled in the top-level module.
package mul_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/iter_multiplier_if.sv
// Operand/result bundle between a requester (master) and the multiplier (slave).
// Handshake: start is accepted on a rising edge where busy=0; ready pulses for one
// cycle when product becomes valid, and product then holds until the next accepted start.
interface mul_if #(parameter int WIDTH = mul_pkg::WIDTH_DEF);
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               start;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               ready;

  modport master (
    output multiplicand, multiplier, start,
    input  product, busy, ready
  );

  modport slave (
    input  multiplicand, multiplier, start,
    output product, busy, ready
  );
endinterface

// File: rtl/iter_multiplier_step.sv
// One combinational shift-add iteration of the multiplier datapath.
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] a_o,
  output logic [WIDTH-1:0]   b_o
);
  always_comb begin
    acc_o = b_i[0] ? (acc_i + a_i) : acc_i;
    a_o   = a_i << 1;
    b_o   = b_i >> 1;
  end
endmodule

// File: rtl/iter_multiplier.sv
// Iterative unsigned multiplier, one shift-add per RUN cycle.
// Define ITER_MUL_EARLY_TERM_EN to leave RUN as soon as the multiplier register empties.
module iter_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic   clk,
  input  logic   clrn,
  mul_if.slave   bus,
  output state_t state_dbg
);
  localparam int CW = cnt_w(WIDTH);

  state_t             state_q,   state_d;
  logic [2*WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0]   b_q,       b_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [2*WIDTH-1:0] acc_step, a_step;
  logic [WIDTH-1:0]   b_step;
  logic               accept, last_iter;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .acc_o (acc_step),
    .a_o   (a_step),
    .b_o   (b_step)
  );

  always_comb begin
    accept = bus.start && (state_q != RUN);
`ifdef ITER_MUL_EARLY_TERM_EN
    last_iter = (b_step == '0);
`else
    last_iter = (cnt_q == CW'(WIDTH - 1));
`endif
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = RUN;
          a_d     = {{WIDTH{1'b0}}, bus.multiplicand};
          b_d     = bus.multiplier;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_step;
        b_d   = b_step;
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        // Product register captures the final sum on the way into DONE.
        if (last_iter) begin
          state_d   = DONE;
          product_d = acc_step;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.ready   = (state_q == DONE);
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_iter_multiplier.sv
// Directed-vector bench for iter_multiplier with hand-computed products and latencies.
// Latency expectations follow the ITER_MUL_EARLY_TERM_EN build option.
module tb_iter_multiplier;
  import mul_pkg::*;

`ifdef ITER_MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  localparam int IGN_CYC = ET ? 2 : 5;
  localparam int RST_CYC = ET ? 2 : 10;

  logic   clk;
  logic   clrn;
  state_t dbg;
  int     total;
  int     bad;

  mul_if #(.WIDTH(32)) bus ();

  iter_multiplier #(.WIDTH(32)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .bus       (bus),
    .state_dbg (dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called at #1 inside cycle 1 of an operation; returns the cycle index in which ready is seen.
  task automatic wait_ready(input int ign_cyc, output int cyc, output int busy_cyc,
                            output int both);
    cyc = 1; busy_cyc = 0; both = 0;
    while (!bus.ready && cyc < 100) begin
      if (bus.busy) busy_cyc++;
      if (ign_cyc != 0 && cyc == ign_cyc) begin
        bus.start = 1'b1; bus.multiplicand = 32'd2; bus.multiplier = 32'd2;
      end else if (ign_cyc != 0 && cyc == ign_cyc + 1) begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (bus.busy && bus.ready) both = 1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_p, input int exp_lat);
    int cyc, bc, both;
    bus.multiplicand = a; bus.multiplier = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.multiplicand = $urandom; bus.multiplier = $urandom;
    wait_ready(0, cyc, bc, both);
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat - 1));
    check({tag, "_busy_with_ready"}, 64'(both), 64'd0);
    check({tag, "_product"}, bus.product, exp_p);
    @(posedge clk); #1;
    check({tag, "_ready_pulse"}, {63'd0, bus.ready}, 64'd0);
    check({tag, "_product_hold"}, bus.product, exp_p);
  endtask

  initial begin
    int cyc, bc, both, rdy_seen;
    total = 0; bad = 0;
    clrn = 1'b0;
    bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
    #1;
    check("reset_product", bus.product, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_ready", {63'd0, bus.ready}, 64'd0);
    check("reset_state", {62'd0, dbg}, {62'd0, IDLE});
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;

    run_op("a99_b3", 32'd99, 32'd3, 64'd297, ET ? 3 : 33);
    run_op("max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
    run_op("b_zero", 32'd123, 32'd0, 64'd0, ET ? 2 : 33);
    run_op("shift16", 32'h1234_5678, 32'h10, 64'h1_2345_6780, ET ? 6 : 33);
    run_op("b_msb", 32'd1, 32'h8000_0000, 64'h8000_0000, 33);
    run_op("mixed", 32'd1000, 32'd1000, 64'd1000000, ET ? 11 : 33);

    // start raised mid-operation with different operands must be ignored
    bus.multiplicand = 32'd7; bus.multiplier = 32'd6; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_ready(IGN_CYC, cyc, bc, both);
    check("ignore_lat", 64'(cyc), 64'(ET ? 4 : 33));
    check("ignore_product", bus.product, 64'd42);
    @(posedge clk); #1;
    check("ignore_no_restart", {63'd0, bus.busy}, 64'd0);

    // Asynchronous reset mid-operation aborts without ready
    bus.multiplicand = 32'd5; bus.multiplier = 32'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < RST_CYC) begin @(posedge clk); #1; cyc++; end
    check("abort_busy_before", {63'd0, bus.busy}, 64'd1);
    clrn = 1'b0;
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_ready", {63'd0, bus.ready}, 64'd0);
    check("abort_product", bus.product, 64'd0);
    check("abort_state", {62'd0, dbg}, {62'd0, IDLE});
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_start_in_reset", {63'd0, bus.busy}, 64'd0);
    bus.start = 1'b0;
    clrn = 1'b1;
    rdy_seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.ready || bus.busy) rdy_seen++; end
    check("abort_no_ready", 64'(rdy_seen), 64'd0);
    run_op("after_reset", 32'd4, 32'd4, 64'd16, ET ? 4 : 33);

    // Back-to-back with start held high throughout
    bus.multiplicand = 32'd3; bus.multiplier = 32'd4; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.multiplicand = 32'd5; bus.multiplier = 32'd6;
    wait_ready(0, cyc, bc, both);
    check("b2b_lat1", 64'(cyc), 64'(ET ? 4 : 33));
    check("b2b_product1", bus.product, 64'd12);
    @(posedge clk); #1;
    check("b2b_rerun_busy", {63'd0, bus.busy}, 64'd1);
    check("b2b_product_held", bus.product, 64'd12);
    bus.multiplicand = $urandom; bus.multiplier = $urandom;
    wait_ready(0, cyc, bc, both);
    check("b2b_lat2", 64'(cyc), 64'(ET ? 4 : 33));
    check("b2b_both", 64'(both), 64'd0);
    check("b2b_product2", bus.product, 64'd30);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("b2b_end_ready", {63'd0, bus.ready}, 64'd0);
    check("b2b_end_state", {62'd0, dbg}, {62'd0, IDLE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iter_multiplier.md
ITER_MULTIPLIER -- requirements
Module: iter_multiplier

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; product is 2*WIDTH bits.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 clrn  input  1  asynchronous active-low reset.
REQ-004 multiplicand  input  WIDTH  unsigned operand A, sampled only on an accepted start.
REQ-005 multiplier  input  WIDTH  unsigned operand B, sampled only on an accepted start.
REQ-006 start  input  1  request; accepted when sampled high while busy=0.
REQ-007 product  output  2*WIDTH  A*B; valid from the ready cycle until the next accepted start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 ready  output  1  one-cycle pulse marking product valid.

Function
REQ-010 States IDLE, RUN, DONE; IDLE->RUN on accepted start; RUN->DONE after the last iteration; DONE->IDLE unconditionally, or DONE->RUN on start.
REQ-011 Accepted start: latch A into a 2*WIDTH shift register (zero-extended), B into a WIDTH shift register, clear the accumulator and the iteration counter, set busy.
REQ-012 Each RUN cycle: if B-register bit0=1, accumulator += A-register; then A-register <<1, B-register >>1, counter +1.
REQ-013 Arithmetic is modulo 2^(2*WIDTH); no overflow is possible, and no carry is dropped.
REQ-014 Without early termination, RUN lasts exactly WIDTH cycles: start sampled at edge 0 -> busy=1 in cycles 1..WIDTH, ready=1 and busy=0 in cycle WIDTH+1.
REQ-015 ready is high only in DONE; busy is high only in RUN; never both.
REQ-016 start while busy=1 is ignored; operands and state are unaffected.
REQ-017 start held high in DONE is accepted (back-to-back); ready still pulses in that cycle, and product updates only when the new operation reaches DONE.
REQ-018 product is driven by a register loaded from the accumulator on entry to DONE and held otherwise.
REQ-019 Operand changes while busy have no effect on the result.

Reset
REQ-020 clrn=0 forces IDLE immediately; product=0, busy=0, ready=0, and all internal registers are 0.
REQ-021 Reset mid-operation aborts the operation; no ready is produced for it.
REQ-022 Reset has priority over start in every state.
REQ-023 After release, the first rising edge with start=1 is accepted normally.

Configuration
REQ-024 Macro ITER_MUL_EARLY_TERM_EN.
REQ-025 Defined: RUN exits to DONE after any iteration that leaves the shifted B-register at zero; latency = msb_index(B)+2 cycles from start to ready; B=0 -> one RUN cycle.
REQ-026 Undefined: fixed WIDTH-iteration latency per REQ-014.
REQ-027 Product values are identical in both builds.

Structure
REQ-028 Package mul_pkg holds the WIDTH default, the state enum typedef (IDLE/RUN/DONE), and the counter width constant $clog2(WIDTH+1).
REQ-029 One sub-module, mul_step: combinational single shift-add iteration (acc, a, b in; acc, a, b out), instantiated once.

Verification
REQ-030 A=99, B=3, start for 1 cycle -> busy for 32 cycles, ready in cycle 33, product=297 (early-term build: ready in cycle 3).
REQ-031 A=0xFFFFFFFF, B=0xFFFFFFFF -> product=0xFFFFFFFE00000001, ready in cycle 33 in both builds.
REQ-032 Start A=7, B=6; in cycle 5 assert start with A=2, B=2 -> ignored; product=42.
REQ-033 Start A=5, B=5; pull clrn low in cycle 10 -> outputs 0 at once, no ready; a new start A=4, B=4 after release -> product=16.
REQ-034 start held high continuously, with A=3, B=4 and then A=5, B=6 presented at the accept points -> ready pulses every 33 cycles; product 12, then 30.
REQ-035 A=123, B=0 -> product=0; the early-term build gives ready in cycle 2.
